// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one transaction at a time, IDLE->REQ->WAIT->DONE, 4 cycles minimum.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses to DONE without touching the bus.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_is_load,
    output logic        out_err
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        out_misalign
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        load_q, load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
    logic        in_misaligned;

    assign in_misaligned = (in_funct3[1:0] == 2'b01 && in_addr[0]) ||
                           (in_funct3 == 3'b010 && in_addr[1:0] != 2'b00);
`endif

    // Shift the addressed lane down first, then extend from the low bits.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b010:  return s;
            3'b100:  return {24'b0, s[7:0]};
            3'b101:  return {16'b0, s[15:0]};
            default: return 32'b0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        load_d   = load_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        rd_d     = rd_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d    = mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    we_d     = in_wen;
                    load_d   = in_ren & ~in_wen;
                    funct3_d = in_funct3;
                    off_d    = in_addr[1:0];
                    addr_d   = {in_addr[31:2], 2'b00};
                    rd_d     = in_rd;
                    rdata_d  = 32'b0;
                    err_d    = 1'b0;
                    cnt_d    = 16'b0;
                    wdata_d  = 32'b0;
                    wmask_d  = 4'b0000;
                    if (in_wen) begin
                        case (in_funct3)
                            3'b000: begin
                                wdata_d = {4{in_wdata[7:0]}};
                                wmask_d = 4'b0001 << in_addr[1:0];
                            end
                            3'b001: begin
                                wdata_d = {2{in_wdata[15:0]}};
                                wmask_d = 4'b0011 << in_addr[1:0];
                            end
                            3'b010: begin
                                wdata_d = in_wdata;
                                wmask_d = 4'b1111;
                            end
                            default: begin
                                wdata_d = in_wdata;
                                wmask_d = 4'b0000;
                            end
                        endcase
                    end
                    state_d = (in_wen || in_ren) ? S_REQ : S_DONE;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_d = 1'b0;
                    if ((in_wen || in_ren) && in_misaligned) begin
                        mis_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = 16'b0;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    state_d = S_DONE;
                    rdata_d = load_q ? load_ext(funct3_q, off_q, bus_rdata) : 32'b0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            load_q   <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rd_q     <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            load_q   <= load_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            rd_q     <= rd_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q    <= mis_d;
`endif
        end
    end

    // Bus fields are only driven while the request is outstanding.
    assign in_ready    = (state_q == S_IDLE);
    assign bus_req     = (state_q == S_REQ);
    assign bus_we      = bus_req & we_q;
    assign bus_addr    = bus_req ? addr_q : 32'b0;
    assign bus_wdata   = bus_req ? wdata_q : 32'b0;
    assign bus_wmask   = bus_req ? wmask_q : 4'b0000;
    assign out_valid   = (state_q == S_DONE);
    assign out_rdata   = rdata_q;
    assign out_rd      = rd_q;
    assign out_is_load = load_q;
    assign out_err     = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign out_misalign = mis_q;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a scoreboard of expected writeback results.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ren, in_wen;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        bus_req, bus_gnt, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wmask;
    logic        out_valid, out_ready, out_is_load, out_err;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        out_misalign;
`endif

    int nerr = 0;
    int nchk = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  rd;
        logic        is_load;
        logic        mis;
    } exp_t;
    exp_t sb[$];

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_rd(out_rd), .out_is_load(out_is_load), .out_err(out_err)
`ifdef LSU_MISALIGN_TRAP_EN
        , .out_misalign(out_misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // rsp_dly < 0 means no response: the transaction must time out exactly 4 cycles after grant.
    task automatic txn(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input bit use_bus, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input logic [3:0] e_mask, input int gnt_dly, input int rsp_dly,
                       input logic [31:0] rdata, input int rdy_dly,
                       input logic [31:0] e_rdata, input logic e_err, input logic e_mis);
        exp_t e;
        int n;
        e.rdata = e_rdata; e.err = e_err; e.rd = rd; e.is_load = ren & ~wen; e.mis = e_mis;
        sb.push_back(e);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1; in_ren = ren; in_wen = wen; in_funct3 = f3;
        in_addr = addr; in_wdata = wdata; in_rd = rd;
        @(negedge clk);
        in_valid = 0; in_ren = $urandom; in_wen = $urandom; in_funct3 = $urandom;
        in_addr = $urandom; in_wdata = $urandom; in_rd = $urandom;
        if (use_bus) begin
            for (int i = 0; i <= gnt_dly; i++) begin
                chk("bus_req", bus_req, 1);
                chk("bus_addr", bus_addr, e_addr);
                chk("bus_we", bus_we, wen);
                chk("bus_wmask", bus_wmask, e_mask);
                if (wen) chk("bus_wdata", bus_wdata, e_wdata);
                chk("in_ready_busy", in_ready, 0);
                if (i == gnt_dly) bus_gnt = 1;
                @(negedge clk);
            end
            bus_gnt = 0;
            chk("bus_req_drop", bus_req, 0);
            if (rsp_dly < 0) begin
                repeat (3) @(negedge clk);
                chk("tmo_not_early", out_valid, 0);
                @(negedge clk);
                chk("tmo_at_4", out_valid, 1);
            end else begin
                repeat (rsp_dly) @(negedge clk);
                bus_rvalid = 1; bus_rdata = rdata;
                @(negedge clk);
                bus_rvalid = 0; bus_rdata = $urandom;
            end
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("out_valid", out_valid, 1);
            chk("out_rdata", out_rdata, e.rdata);
            chk("out_err", out_err, e.err);
            chk("out_rd", out_rd, e.rd);
            chk("out_is_load", out_is_load, e.is_load);
            chk("in_ready_done", in_ready, 0);
`ifdef LSU_MISALIGN_TRAP_EN
            chk("out_misalign", out_misalign, e.mis);
`endif
            if (i == rdy_dly) out_ready = 1;
            @(negedge clk);
        end
        out_ready = 0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_ren = 0; in_wen = 0; in_funct3 = 0; in_addr = 0;
        in_wdata = 0; in_rd = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rdata", out_rdata, 0);
        chk("rst_out_err", out_err, 0);
        rst = 0;
        @(negedge clk);

        // SB to byte 3: lane replication and top-lane mask
        txn(0, 1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 5'd1, 1, 32'h8000_0000, 32'hA5A5_A5A5,
            4'b1000, 0, 0, 32'hDEAD_BEEF, 0, 32'h0, 0, 0);
        // LH / LHU on upper half
        txn(1, 0, 3'b001, 32'h1000_0002, 32'h0, 5'd2, 1, 32'h1000_0000, 32'h0, 4'b0000,
            0, 0, 32'h8123_4567, 0, 32'hFFFF_8123, 0, 0);
        txn(1, 0, 3'b101, 32'h1000_0002, 32'h0, 5'd3, 1, 32'h1000_0000, 32'h0, 4'b0000,
            0, 0, 32'h8123_4567, 0, 32'h0000_8123, 0, 0);
        // Backpressure on both grant and writeback
        txn(0, 1, 3'b001, 32'h2000_0001, 32'h0000_BEEF, 5'd4, 1, 32'h2000_0000, 32'hBEEF_BEEF,
            4'b0110, 5, 2, 32'h0, 3, 32'h0, 0, 0);
        // LB sign, LBU zero
        txn(1, 0, 3'b000, 32'h4000_0001, 32'h0, 5'd5, 1, 32'h4000_0000, 32'h0, 4'b0000,
            1, 1, 32'h0000_8000, 0, 32'hFFFF_FF80, 0, 0);
        txn(1, 0, 3'b100, 32'h4000_0003, 32'h0, 5'd6, 1, 32'h4000_0000, 32'h0, 4'b0000,
            0, 0, 32'h7F00_0000, 0, 32'h0000_007F, 0, 0);
        // LW, SW
        txn(1, 0, 3'b010, 32'h5000_0010, 32'h0, 5'd7, 1, 32'h5000_0010, 32'h0, 4'b0000,
            0, 0, 32'h1234_5678, 1, 32'h1234_5678, 0, 0);
        txn(0, 1, 3'b010, 32'h5000_0004, 32'hCAFE_BABE, 5'd8, 1, 32'h5000_0004, 32'hCAFE_BABE,
            4'b1111, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        // Neither ren nor wen: pass-through
        txn(0, 0, 3'b010, 32'h6000_0000, 32'h0, 5'd9, 0, 32'h0, 32'h0, 4'b0000,
            0, 0, 32'h0, 1, 32'h0, 0, 0);
        // Both set: store wins
        txn(1, 1, 3'b010, 32'h6000_0008, 32'h0102_0304, 5'd10, 1, 32'h6000_0008, 32'h0102_0304,
            4'b1111, 0, 0, 32'hFFFF_FFFF, 0, 32'h0, 0, 0);
        // Undefined load width returns 0
        txn(1, 0, 3'b011, 32'h6000_000C, 32'h0, 5'd11, 1, 32'h6000_000C, 32'h0, 4'b0000,
            0, 0, 32'hFFFF_FFFF, 0, 32'h0, 0, 0);
        // Timeout then a stray rvalid in IDLE
        txn(1, 0, 3'b010, 32'h7000_0008, 32'h0, 5'd12, 1, 32'h7000_0008, 32'h0, 4'b0000,
            0, -1, 32'h0, 0, 32'h0, 1, 0);
        bus_rvalid = 1; bus_rdata = 32'h5555_5555;
        @(negedge clk);
        bus_rvalid = 0;
        chk("late_rvalid_in_ready", in_ready, 1);
        chk("late_rvalid_out_valid", out_valid, 0);
        chk("late_rvalid_bus_req", bus_req, 0);

        // Reset mid-WAIT
        in_valid = 1; in_ren = 1; in_wen = 0; in_funct3 = 3'b010; in_addr = 32'h7000_0000;
        in_rd = 5'd13;
        @(negedge clk);
        in_valid = 0; bus_gnt = 1;
        @(negedge clk);
        bus_gnt = 0;
        chk("wait_bus_req", bus_req, 0);
        chk("wait_in_ready", in_ready, 0);
        #2 rst = 1;
        #1;
        chk("amid_rst_in_ready", in_ready, 1);
        chk("amid_rst_out_valid", out_valid, 0);
        chk("amid_rst_out_rd", out_rd, 0);
        chk("amid_rst_out_is_load", out_is_load, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        txn(1, 0, 3'b001, 32'h7000_0000, 32'h0, 5'd14, 1, 32'h7000_0000, 32'h0, 4'b0000,
            0, 0, 32'h0000_7FFF, 0, 32'h0000_7FFF, 0, 0);

        // Misaligned word / halfword
`ifdef LSU_MISALIGN_TRAP_EN
        txn(1, 0, 3'b010, 32'h9000_0001, 32'h0, 5'd15, 0, 32'h0, 32'h0, 4'b0000,
            0, 0, 32'h0, 0, 32'h0, 1, 1);
        txn(0, 1, 3'b001, 32'h9000_0003, 32'h1234, 5'd16, 0, 32'h0, 32'h0, 4'b0000,
            0, 0, 32'h0, 0, 32'h0, 1, 1);
`else
        txn(1, 0, 3'b010, 32'h9000_0001, 32'h0, 5'd15, 1, 32'h9000_0000, 32'h0, 4'b0000,
            0, 0, 32'h1122_3344, 0, 32'h0011_2233, 0, 0);
        txn(0, 1, 3'b001, 32'h9000_0003, 32'h0000_1234, 5'd16, 1, 32'h9000_0000, 32'h1234_1234,
            4'b1000, 0, 0, 32'h0, 0, 32'h0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
